// File: rtl/signal_checker_mc.sv
// rtl/signal_checker_mc.sv - multi-channel goal/timeout/hold signal checker with sticky fail status
module signal_checker_mc #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int TW     = 16,
  parameter int TOL    = 0,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH-1:0]        abort,
  input  logic [NUM_CH*WIDTH-1:0]  sig,
  input  logic [NUM_CH*WIDTH-1:0]  goal,
  input  logic [NUM_CH*TW-1:0]     timeout_cyc,
  input  logic [NUM_CH*TW-1:0]     hold_cyc,
  input  logic                     clear,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH*2-1:0]      result,
  output logic                     fail_any,
  output logic [CNT_W-1:0]         err_count
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_HOLD = 2'd2} state_t;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_PASS    = 2'b01;
  localparam logic [1:0] RES_TIMEOUT = 2'b10;
  localparam logic [1:0] RES_FLAKE   = 2'b11;

  // Tolerance at the widened width, so |sig - goal| compares without overflow.
  localparam logic [WIDTH:0] TOL_V = (WIDTH+1)'(TOL);
  localparam int NF_W  = $clog2(NUM_CH + 1);
  localparam int SUM_W = CNT_W + NF_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Per-channel "this edge produces a timeout or flake verdict" flags.
  logic [NUM_CH-1:0] fail_hit;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           st_q, st_d;
    logic [WIDTH-1:0] goal_q, goal_d;
    logic [TW-1:0]    tlim_q, tlim_d;
    logic [TW-1:0]    hlim_q, hlim_d;
    logic [TW-1:0]    wcnt_q, wcnt_d;
    logic [TW-1:0]    hcnt_q, hcnt_d;
    logic [1:0]       res_q, res_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sig_c;
    logic [TW-1:0]    t_in;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   mag;
    logic             match;

    assign sig_c = sig[c*WIDTH +: WIDTH];
    assign t_in  = timeout_cyc[c*TW +: TW];

    // Sign-extended difference and its magnitude against the latched goal.
    always_comb begin
      diff  = {sig_c[WIDTH-1], sig_c} - {goal_q[WIDTH-1], goal_q};
      mag   = diff[WIDTH] ? ((WIDTH+1)'(0) - diff) : diff;
      match = (mag <= TOL_V);
    end

    // Next-state and verdict logic; abort outranks any verdict on the same edge.
    always_comb begin
      st_d   = st_q;
      goal_d = goal_q;
      tlim_d = tlim_q;
      hlim_d = hlim_q;
      wcnt_d = wcnt_q;
      hcnt_d = hcnt_q;
      res_d  = res_q;
      done_d = 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (start[c] && !abort[c]) begin
            st_d   = ST_WAIT;
            goal_d = goal[c*WIDTH +: WIDTH];
            tlim_d = (t_in == '0) ? TW'(1) : t_in;
            hlim_d = hold_cyc[c*TW +: TW];
            wcnt_d = '0;
            hcnt_d = '0;
            res_d  = RES_NONE;
          end
        end
        ST_WAIT: begin
          if (abort[c]) begin
            st_d = ST_IDLE;
          end else begin
            if (wcnt_q != tlim_q) wcnt_d = wcnt_q + TW'(1);
            if (match) begin
              if (hlim_q == '0) begin
                st_d   = ST_IDLE;
                res_d  = RES_PASS;
                done_d = 1'b1;
              end else begin
                st_d   = ST_HOLD;
                hcnt_d = '0;
              end
            end else if (wcnt_q == tlim_q - TW'(1)) begin
              st_d   = ST_IDLE;
              res_d  = RES_TIMEOUT;
              done_d = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (abort[c]) begin
            st_d = ST_IDLE;
          end else if (match) begin
            if (hcnt_q != hlim_q) hcnt_d = hcnt_q + TW'(1);
            if (hcnt_q == hlim_q - TW'(1)) begin
              st_d   = ST_IDLE;
              res_d  = RES_PASS;
              done_d = 1'b1;
            end
          end else begin
            st_d   = ST_IDLE;
            res_d  = RES_FLAKE;
            done_d = 1'b1;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q   <= ST_IDLE;
        goal_q <= '0;
        tlim_q <= '0;
        hlim_q <= '0;
        wcnt_q <= '0;
        hcnt_q <= '0;
        res_q  <= RES_NONE;
        done_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        goal_q <= goal_d;
        tlim_q <= tlim_d;
        hlim_q <= hlim_d;
        wcnt_q <= wcnt_d;
        hcnt_q <= hcnt_d;
        res_q  <= res_d;
        done_q <= done_d;
      end
    end

    assign fail_hit[c]        = done_d & res_d[1];
    assign busy[c]            = (st_q != ST_IDLE);
    assign done[c]            = done_q;
    assign result[2*c +: 2]   = res_q;
  end

  logic [NF_W-1:0]  nf;
  logic [CNT_W-1:0] base;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_d;
  logic             fail_d;

  // Count this edge's failures; clear wipes the old totals before they are added.
  always_comb begin
    nf = '0;
    for (int c = 0; c < NUM_CH; c++) nf = nf + NF_W'(fail_hit[c]);
    base   = clear ? '0 : err_count;
    sum    = SUM_W'(base) + SUM_W'(nf);
    cnt_d  = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    fail_d = (fail_any & ~clear) | (nf != '0);
  end

  // Sticky aggregate status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_any  <= 1'b0;
      err_count <= '0;
    end else begin
      fail_any  <= fail_d;
      err_count <= cnt_d;
    end
  end

endmodule
